// File: rtl/dmem_access_ctrl_pkg.sv
// Shared state encoding, width defaults and address checks for the data-memory
// access controller.
package mem_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Accesses are halfword-wide, so any odd byte address is misaligned.
    function automatic logic is_misaligned(input logic addr_lsb);
        return addr_lsb;
    endfunction
endpackage

// File: rtl/dmem_access_ctrl_timeout_ctr.sv
// Clear/enable cycle counter that flags the last permitted wait cycle.
module timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TC_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [W-1:0] TC_VAL = W'(TC_INT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero TIMEOUT means wait forever for the memory.
    if (TIMEOUT > 0) begin : g_tc
        assign tc_o = (cnt_q == TC_VAL);
    end else begin : g_no_tc
        assign tc_o = 1'b0;
    end
endmodule

// File: rtl/register.sv
// Generic write-enabled flop bank with asynchronous active-low clear.
module register #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: runs one load/store through the multi-cycle data memory
// handshake and stalls the upstream pipeline until the access completes.
module dmem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_memEn,
    input  logic              EX_memWr,
    input  logic [ADDR_W-1:0] EX_addr,
    input  logic [DATA_W-1:0] EX_wdata,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              MEM_stall,
    output logic              MEM_valid,
    output logic [DATA_W-1:0] MEM_readData,
    output logic              MEM_err
);
    localparam int REQ_W = 1 + ADDR_W + DATA_W;

    state_e           state_q, state_d;
    logic             err_q, err_d;
    logic             mem_en_q;
    logic             capture, accept, rd_we, ctr_clr, ctr_en, tmo;
    logic             wr_q;
    logic [REQ_W-1:0] req_q;

    assign capture = (state_q == ST_IDLE) && EX_memEn && !flush;
    assign accept  = mem_en_q && !mem_busy;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rd_we   = 1'b0;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    err_d   = is_misaligned(EX_addr[0]);
                    state_d = err_d ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A flush racing an accept still leaves a request in flight to drain.
                if (accept) begin
                    ctr_clr = 1'b1;
                    state_d = flush ? ST_DRAIN : ST_WAIT;
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                ctr_en = 1'b1;
                if (flush) begin
                    state_d = (mem_done || tmo) ? ST_IDLE : ST_DRAIN;
                end else if (mem_done) begin
                    rd_we   = !wr_q;
                    state_d = ST_DONE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                ctr_en = 1'b1;
                if (mem_done || tmo) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            mem_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            mem_en_q <= (state_d == ST_ISSUE);
        end
    end

    register #(.W(REQ_W)) u_req (
        .clk  (clk),
        .rst  (rst),
        .en_i (capture),
        .d_i  ({EX_memWr, EX_addr, EX_wdata}),
        .q_o  (req_q)
    );

    register #(.W(DATA_W)) u_rdata (
        .clk  (clk),
        .rst  (rst),
        .en_i (rd_we),
        .d_i  (mem_rdata),
        .q_o  (MEM_readData)
    );

    timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr_i (ctr_clr),
        .en_i  (ctr_en),
        .tc_o  (tmo)
    );

    assign wr_q      = req_q[REQ_W-1];
    assign mem_wr    = wr_q;
    assign mem_addr  = req_q[DATA_W +: ADDR_W];
    assign mem_wdata = req_q[DATA_W-1:0];
    assign mem_en    = mem_en_q;

    // The IDLE term looks at live inputs, so hold it low while reset is asserted.
    assign MEM_stall = (rst && capture) || (state_q == ST_ISSUE) ||
                       (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    assign MEM_valid = (state_q == ST_DONE);
    assign MEM_err   = (state_q == ST_DONE) && err_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized
// transactions checked against a cycle-count model of each access.
module tb_dmem_access_ctrl;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              EX_memEn = 1'b0;
    logic              EX_memWr = 1'b0;
    logic [ADDR_W-1:0] EX_addr = '0;
    logic [DATA_W-1:0] EX_wdata = '0;
    logic              flush = 1'b0;
    logic              mem_en, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_busy = 1'b0;
    logic              mem_done = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              MEM_stall, MEM_valid, MEM_err;
    logic [DATA_W-1:0] MEM_readData;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] ref_rd = '0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .EX_memEn(EX_memEn), .EX_memWr(EX_memWr),
        .EX_addr(EX_addr), .EX_wdata(EX_wdata), .flush(flush),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .MEM_stall(MEM_stall), .MEM_valid(MEM_valid), .MEM_readData(MEM_readData),
        .MEM_err(MEM_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One access: memory busy for busy_n ISSUE cycles, done in WAIT cycle lat.
    // Expected timing follows from cycle arithmetic: IDLE(1) + ISSUE(busy_n+1) + WAIT(lat+1) + DONE.
    task automatic run_txn(input string name, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int busy_n, input int lat,
                           input logic [DATA_W-1:0] rdata, input int tail, input logic flush_done);
        int done_cyc, done_sched, exp_en;
        int n_stall, n_en, n_valid, valid_cyc, bad_req;
        logic exp_err, got_err;
        logic [DATA_W-1:0] exp_rd, got_rd;
        n_stall = 0; n_en = 0; n_valid = 0; valid_cyc = -1; bad_req = 0;
        got_err = 1'b0; got_rd = '0;
        if (addr[0]) begin
            done_cyc = 1; exp_err = 1'b1; exp_en = 0; done_sched = -1;
        end else begin
            exp_en = busy_n + 1;
            done_sched = busy_n + 2 + lat;
            if (lat < TIMEOUT) begin
                done_cyc = busy_n + 3 + lat; exp_err = 1'b0;
            end else begin
                done_cyc = busy_n + 2 + TIMEOUT; exp_err = 1'b1;
            end
        end
        exp_rd = (!wr && !exp_err) ? rdata : ref_rd;
        $display("[TB] txn %s wr=%0d addr=%h wdata=%h busy=%0d lat=%0d rdata=%h", name, wr, addr,
                 wdata, busy_n, lat, rdata);
        for (int c = 0; c <= done_cyc + tail; c++) begin
            EX_memEn  = (c <= done_cyc);
            EX_memWr  = wr;
            EX_addr   = addr;
            EX_wdata  = wdata;
            flush     = flush_done && (c == done_cyc);
            mem_busy  = (c >= 1) && (c <= busy_n);
            mem_done  = (c == done_sched);
            mem_rdata = (c == done_sched) ? rdata : DATA_W'($urandom);
            @(negedge clk);
            if (MEM_stall) n_stall++;
            if (mem_en) begin
                n_en++;
                if (mem_wr !== wr || mem_addr !== addr || mem_wdata !== wdata) bad_req++;
            end
            if (MEM_valid) begin
                n_valid++; valid_cyc = c; got_err = MEM_err; got_rd = MEM_readData;
            end
            @(posedge clk); #1;
        end
        EX_memEn = 1'b0; flush = 1'b0; mem_busy = 1'b0; mem_done = 1'b0;
        ref_rd = exp_rd;
        tests++; if (n_stall !== done_cyc) begin fails++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, n_stall, done_cyc); end
        tests++; if (n_valid !== 1) begin fails++;
            $display("FAIL %s valid_pulses: got %0d expected 1", name, n_valid); end
        tests++; if (valid_cyc !== done_cyc) begin fails++;
            $display("FAIL %s valid_cycle: got %0d expected %0d", name, valid_cyc, done_cyc); end
        tests++; if (got_err !== exp_err) begin fails++;
            $display("FAIL %s err: got %0b expected %0b", name, got_err, exp_err); end
        tests++; if (got_rd !== exp_rd) begin fails++;
            $display("FAIL %s readData: got %h expected %h", name, got_rd, exp_rd); end
        tests++; if (n_en !== exp_en) begin fails++;
            $display("FAIL %s mem_en_cycles: got %0d expected %0d", name, n_en, exp_en); end
        tests++; if (bad_req !== 0) begin fails++;
            $display("FAIL %s request_fields: got %0d bad cycles expected 0", name, bad_req); end
    endtask

    task automatic test_reset();
        EX_memEn = 1'b1;
        #12;
        tests++; if (MEM_stall !== 1'b0 || mem_en !== 1'b0) begin fails++;
            $display("FAIL reset_stall_en: got stall=%b en=%b expected 0 0", MEM_stall, mem_en); end
        tests++; if (MEM_valid !== 1'b0 || MEM_err !== 1'b0) begin fails++;
            $display("FAIL reset_valid_err: got %b %b expected 0 0", MEM_valid, MEM_err); end
        tests++; if (MEM_readData !== '0) begin fails++;
            $display("FAIL reset_readData: got %h expected 0000", MEM_readData); end
        @(negedge clk);
        EX_memEn = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_basic();
        run_txn("load_basic", 1'b0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 2, 1'b0);
    endtask

    task automatic test_store_busy();
        run_txn("store_busy", 1'b1, 16'h0020, 16'h1234, 3, 0, 16'h5555, 2, 1'b0);
    endtask

    task automatic test_misaligned();
        run_txn("misaligned_load", 1'b0, 16'h0011, 16'h0000, 0, 0, 16'h7777, 2, 1'b0);
        run_txn("misaligned_store", 1'b1, 16'h0101, 16'hCAFE, 0, 0, 16'h7777, 1, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn("timeout_stray_done", 1'b0, 16'h0030, 16'h0000, 1, 12, 16'h1111, 6, 1'b0);
        run_txn("done_at_last_cycle", 1'b0, 16'h0032, 16'h0000, 0, TIMEOUT - 1, 16'h2222, 1, 1'b0);
        run_txn("timeout_done_in_done", 1'b0, 16'h0034, 16'h0000, 0, TIMEOUT, 16'h3333, 2, 1'b0);
    endtask

    task automatic test_flush();
        // Flush in IDLE with a pending request: ignored entirely.
        EX_memEn = 1'b1; EX_memWr = 1'b0; EX_addr = 16'h0050; flush = 1'b1;
        @(negedge clk);
        tests++; if (MEM_stall !== 1'b0) begin fails++;
            $display("FAIL flush_idle_stall: got %b expected 0", MEM_stall); end
        @(posedge clk); #1;
        EX_memEn = 1'b0; flush = 1'b0;
        @(negedge clk);
        tests++; if (mem_en !== 1'b0 || MEM_stall !== 1'b0) begin fails++;
            $display("FAIL flush_idle_noissue: got en=%b stall=%b expected 0 0", mem_en, MEM_stall); end
        @(posedge clk); #1;
        // Flush in ISSUE while busy: back to IDLE without an accepted request.
        EX_memEn = 1'b1; EX_addr = 16'h0040; mem_busy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (mem_en !== 1'b1) begin fails++;
            $display("FAIL flush_issue_en: got %b expected 1", mem_en); end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; EX_memEn = 1'b0; mem_busy = 1'b0;
        @(negedge clk);
        tests++; if (mem_en !== 1'b0 || MEM_stall !== 1'b0 || MEM_valid !== 1'b0) begin fails++;
            $display("FAIL flush_issue_idle: got en=%b stall=%b valid=%b expected 0 0 0",
                     mem_en, MEM_stall, MEM_valid); end
        @(posedge clk); #1;
        // Flush in WAIT: drain the late completion and discard its data.
        EX_memEn = 1'b1; EX_addr = 16'h0042;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; EX_memEn = 1'b0;
        @(negedge clk);
        tests++; if (MEM_stall !== 1'b1 || MEM_valid !== 1'b0) begin fails++;
            $display("FAIL flush_drain_stall: got stall=%b valid=%b expected 1 0", MEM_stall, MEM_valid); end
        @(posedge clk); #1;
        mem_done = 1'b1; mem_rdata = 16'hAAAA;
        @(negedge clk);
        tests++; if (MEM_valid !== 1'b0) begin fails++;
            $display("FAIL flush_drain_valid: got %b expected 0", MEM_valid); end
        @(posedge clk); #1;
        mem_done = 1'b0;
        @(negedge clk);
        tests++; if (MEM_stall !== 1'b0 || MEM_valid !== 1'b0 || MEM_readData !== ref_rd) begin fails++;
            $display("FAIL flush_drain_exit: got stall=%b valid=%b rd=%h expected 0 0 %h",
                     MEM_stall, MEM_valid, MEM_readData, ref_rd); end
        @(posedge clk); #1;
        run_txn("after_flush", 1'b0, 16'h0044, 16'h0000, 0, 1, 16'h4444, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_0", 1'b0, 16'h0200, 16'h0000, 0, 0, 16'h0F0F, 0, 1'b0);
        run_txn("b2b_1", 1'b1, 16'h0202, 16'h9876, 1, 0, 16'h0000, 0, 1'b1);
        run_txn("b2b_2", 1'b0, 16'h0204, 16'h0000, 0, 2, 16'hF00D, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 5) == 0) a[0] = 1'b1;
            run_txn("random", 1'($urandom_range(0, 1)), a, DATA_W'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 10), DATA_W'($urandom),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_async_reset();
        run_txn("pre_reset_load", 1'b0, 16'h0300, 16'h0000, 0, 0, 16'h5A5A, 1, 1'b0);
        EX_memEn = 1'b1; EX_memWr = 1'b0; EX_addr = 16'h0060;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (MEM_stall !== 1'b1) begin fails++;
            $display("FAIL async_pre_stall: got %b expected 1", MEM_stall); end
        #2 rst = 1'b0;
        #1;
        tests++; if (MEM_stall !== 1'b0 || mem_en !== 1'b0 || MEM_valid !== 1'b0) begin fails++;
            $display("FAIL async_outputs: got stall=%b en=%b valid=%b expected 0 0 0",
                     MEM_stall, mem_en, MEM_valid); end
        tests++; if (MEM_readData !== '0) begin fails++;
            $display("FAIL async_readData: got %h expected 0000", MEM_readData); end
        @(negedge clk);
        EX_memEn = 1'b0;
        rst = 1'b1;
        ref_rd = '0;
        @(posedge clk); #1;
        run_txn("post_reset_load", 1'b0, 16'h0062, 16'h0000, 0, 0, 16'h6161, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_busy();
        test_misaligned();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
